enemy_spawn_scheduler: RTL and testbench



---
 rtl/enemy_spawn_scheduler_pkg.sv | 68 ++++++
 rtl/enemy_spawn_scheduler_spawn_timer.sv | 40 ++++
 rtl/enemy_spawn_scheduler.sv | 160 ++++++++++++++++
 tb/tb_enemy_spawn_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared widths, tuning constants and FSM encoding for the enemy spawn scheduler.
package enemy_spawn_scheduler_pkg;

    localparam int RAND_WIDTH          = 16;
    localparam int H_DISP_LEN          = 11;
    localparam int ADD_SCORE_BIT_WIDTH = 8;
    localparam int ENEMY_CLASS_NUM     = 3;

    localparam int TIMER_W     = 10;
    localparam int HOLD_W      = 7;
    localparam int ACC_W       = 16;
    localparam int LEVEL_SCORE = 200;
    localparam int MAX_LEVEL   = 7;
    localparam int BOMB_HOLD   = 90;

    // 2^H_DISP_LEN / X_RANGE3 < 5, so four subtracts fully reduce any r
    localparam int X_SUB_STEPS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int base_period(input int k);
        case (k)
            0:       return 60;
            1:       return 180;
            default: return 600;
        endcase
    endfunction

    function automatic int step_period(input int k);
        case (k)
            0:       return 6;
            1:       return 16;
            default: return 48;
        endcase
    endfunction

    function automatic int min_period(input int k);
        case (k)
            0:       return 20;
            1:       return 60;
            default: return 240;
        endcase
    endfunction

    function automatic logic [H_DISP_LEN-1:0] x_range_of(input int k);
        case (k)
            0:       return H_DISP_LEN'(583);
            1:       return H_DISP_LEN'(571);
            default: return H_DISP_LEN'(471);
        endcase
    endfunction

    // Signed int arithmetic keeps base - level*step from wrapping
    function automatic logic [TIMER_W-1:0] class_period(
        input int         k,
        input logic [2:0] level
    );
        int p;
        p = base_period(k) - int'(level) * step_period(k);
        if (p < min_period(k)) p = min_period(k);
        return TIMER_W'(p);
    endfunction

endpackage

// File: rtl/enemy_spawn_scheduler_spawn_timer.sv
// Per-class frame down-counter with a sticky pending flag.
module spawn_timer
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter logic [TIMER_W-1:0] BASE = TIMER_W'(60)
) (
    input  logic               clk_run,
    input  logic               rst,
    input  logic               restart,
    input  logic               tick,
    input  logic               reload,
    input  logic [TIMER_W-1:0] period,
    output logic               pending
);

    logic [TIMER_W-1:0] cnt;
    logic               pend_q;
    logic               expire;

    // Expiry is visible in the same tick so it can be granted at once
    assign expire  = tick & ~pend_q & (cnt == TIMER_W'(1));
    assign pending = pend_q | expire;

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            cnt    <= BASE;
            pend_q <= 1'b0;
        end else if (restart) begin
            cnt    <= BASE;
            pend_q <= 1'b0;
        end else if (reload) begin
            cnt    <= period;
            pend_q <= 1'b0;
        end else if (tick && !pend_q) begin
            cnt <= cnt - TIMER_W'(1);
            if (cnt == TIMER_W'(1)) pend_q <= 1'b1;
        end
    end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Shares one spawn per frame between three enemy classes, with
// score-driven difficulty and a post-bomb spawn blackout.
module enemy_spawn_scheduler
    import enemy_spawn_scheduler_pkg::*;
(
    input  logic                           clk_run,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic                           v_sync_i,
    input  logic [RAND_WIDTH-1:0]          rand_i,
    input  logic [ENEMY_CLASS_NUM-1:0]     busy_i,
    input  logic [ADD_SCORE_BIT_WIDTH-1:0] add_score_i,
    input  logic                           bomb_i,
    output logic [ENEMY_CLASS_NUM-1:0]     spawn_o,
    output logic [H_DISP_LEN-1:0]          spawn_x_o,
    output logic [2:0]                     level_o
);

    state_t                     state, state_n;
    logic [HOLD_W-1:0]          hold_cnt, hold_n;
    logic [2:0]                 vs;
    logic                       frame_tick;
    logic                       bomb_q;
    logic                       bomb_edge;
    logic                       grant_ok;
    logic                       timer_tick;
    logic [ENEMY_CLASS_NUM-1:0] pending;
    logic [ENEMY_CLASS_NUM-1:0] elig;
    logic [ENEMY_CLASS_NUM-1:0] grant;
    logic [TIMER_W-1:0]         cur_period [ENEMY_CLASS_NUM];
    logic [H_DISP_LEN-1:0]      x_range;
    logic [H_DISP_LEN-1:0]      x_red;
    logic [ACC_W-1:0]           acc;
    logic [ACC_W:0]             sum;
    logic [ACC_W-1:0]           sat;

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            vs         <= '0;
            frame_tick <= 1'b0;
            bomb_q     <= 1'b0;
        end else begin
            vs         <= {vs[1:0], v_sync_i};
            frame_tick <= vs[1] & ~vs[2];
            bomb_q     <= bomb_i;
        end
    end

    assign bomb_edge = bomb_i & ~bomb_q;

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        grant_ok = 1'b0;
        unique case (state)
            IDLE: if (en_i) state_n = RUN;
            RUN: begin
                if (bomb_edge) begin
                    state_n = HOLD;
                    hold_n  = HOLD_W'(BOMB_HOLD);
                end else begin
                    grant_ok = frame_tick;
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    hold_n = hold_cnt - HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(1)) state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!en_i) begin
            state_n  = IDLE;
            hold_n   = '0;
            grant_ok = 1'b0;
        end
    end

    assign timer_tick = frame_tick & (state != IDLE);
    assign elig       = pending & ~busy_i;

    always_comb begin
        grant = '0;
        if (grant_ok) begin
            if (elig[2])      grant = 3'b100;
            else if (elig[1]) grant = 3'b010;
            else if (elig[0]) grant = 3'b001;
        end
    end

    always_comb begin
        for (int k = 0; k < ENEMY_CLASS_NUM; k++) begin
            cur_period[k] = class_period(k, level_o);
        end
    end

    for (genvar k = 0; k < ENEMY_CLASS_NUM; k++) begin : g_timer
        spawn_timer #(
            .BASE(TIMER_W'(base_period(k)))
        ) u_timer (
            .clk_run(clk_run),
            .rst    (rst),
            .restart(~en_i),
            .tick   (timer_tick),
            .reload (grant[k]),
            .period (cur_period[k]),
            .pending(pending[k])
        );
    end

    always_comb begin
        x_range = x_range_of(0);
        if (grant[2])      x_range = x_range_of(2);
        else if (grant[1]) x_range = x_range_of(1);
        x_red = rand_i[H_DISP_LEN-1:0];
        for (int i = 0; i < X_SUB_STEPS; i++) begin
            if (x_red >= x_range) x_red = x_red - x_range;
        end
    end

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            spawn_o   <= '0;
            spawn_x_o <= '0;
        end else begin
            spawn_o <= grant;
            if (|grant) spawn_x_o <= x_red;
        end
    end

    assign sum = {1'b0, acc} + (ACC_W + 1)'(add_score_i);
    assign sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            level_o <= '0;
        end else if (state != IDLE) begin
            if (sat >= ACC_W'(LEVEL_SCORE) &&
                level_o != 3'(MAX_LEVEL)) begin
                acc     <= sat - ACC_W'(LEVEL_SCORE);
                level_o <= level_o + 3'd1;
            end else begin
                acc <= sat;
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed scenarios with random x sources, checked against a frame-level
// model of periods, pending flags, priority, bomb blackout and level.
module tb_enemy_spawn_scheduler;
    import enemy_spawn_scheduler_pkg::*;

    logic                           clk_run = 1'b0;
    logic                           rst;
    logic                           en_i;
    logic                           v_sync_i;
    logic [RAND_WIDTH-1:0]          rand_i;
    logic [2:0]                     busy_i;
    logic [ADD_SCORE_BIT_WIDTH-1:0] add_score_i;
    logic                           bomb_i;
    logic [2:0]                     spawn_o;
    logic [H_DISP_LEN-1:0]          spawn_x_o;
    logic [2:0]                     level_o;

    enemy_spawn_scheduler dut (
        .clk_run    (clk_run),
        .rst        (rst),
        .en_i       (en_i),
        .v_sync_i   (v_sync_i),
        .rand_i     (rand_i),
        .busy_i     (busy_i),
        .add_score_i(add_score_i),
        .bomb_i     (bomb_i),
        .spawn_o    (spawn_o),
        .spawn_x_o  (spawn_x_o),
        .level_o    (level_o)
    );

    always #5 clk_run = ~clk_run;

    int errors = 0;
    int checks = 0;

    int MB [3] = '{60, 180, 600};
    int MS [3] = '{6, 16, 48};
    int MM [3] = '{20, 60, 240};
    int XR [3] = '{583, 571, 471};

    int rem [3];
    bit pend [3];
    int total;
    bit running;
    bit held;
    int held_left;
    int fnum;
    int spawn_log [1024];
    logic [2:0]  last_sp;
    logic [10:0] last_x;

    function automatic int m_level();
        int l;
        l = total / 200;
        return (l > 7) ? 7 : l;
    endfunction

    function automatic int m_period(input int k);
        int p;
        p = MB[k] - m_level() * MS[k];
        return (p < MM[k]) ? MM[k] : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s frame=%0d observed=%0d expected=%0d",
                   tag, fnum, obs, exp);
        end
    endtask

    task automatic model_idle();
        for (int k = 0; k < 3; k++) begin
            rem[k]  = MB[k];
            pend[k] = 0;
        end
        running   = 0;
        held      = 0;
        held_left = 0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        en_i        = 1'b0;
        v_sync_i    = 1'b0;
        bomb_i      = 1'b0;
        busy_i      = 3'b000;
        add_score_i = '0;
        rand_i      = '0;
        repeat (2) @(posedge clk_run);
        #1;
        rst = 1'b0;
        model_idle();
        total = 0;
        fnum  = 0;
        for (int i = 0; i < 1024; i++) spawn_log[i] = 0;
        @(posedge clk_run);
        #1;
    endtask

    task automatic start();
        en_i = 1'b1;
        @(posedge clk_run);
        #1;
        running = 1;
        fnum    = 0;
        for (int i = 0; i < 1024; i++) spawn_log[i] = 0;
    endtask

    task automatic frame(input int force_r, input bit hit_rst);
        int exp_sp;
        int exp_x;
        exp_sp = 0;
        exp_x  = 0;
        if (force_r >= 0) rand_i = 16'(force_r);
        else rand_i = 16'($urandom);
        v_sync_i = 1'b1;
        repeat (3) @(posedge clk_run);
        #1;
        chk("pre_tick_quiet", 32'(spawn_o), 0);
        @(posedge clk_run);
        #1;
        fnum++;
        if (running) begin
            for (int k = 0; k < 3; k++) begin
                if (!pend[k]) begin
                    rem[k]--;
                    if (rem[k] == 0) pend[k] = 1;
                end
            end
            if (held) begin
                held_left--;
                if (held_left == 0) held = 0;
            end else begin
                for (int k = 2; k >= 0; k--) begin
                    if (exp_sp == 0 && pend[k] && !busy_i[k]) begin
                        exp_sp  = 1 << k;
                        pend[k] = 0;
                        rem[k]  = m_period(k);
                        exp_x   = (int'(rand_i) & 2047) % XR[k];
                    end
                end
            end
        end
        last_sp = spawn_o;
        last_x  = spawn_x_o;
        if (fnum < 1024) spawn_log[fnum] = int'(spawn_o);
        chk("spawn", 32'(spawn_o), exp_sp);
        if (exp_sp != 0) chk("spawn_x", 32'(spawn_x_o), exp_x);
        v_sync_i = 1'b0;
        if (hit_rst) begin
            rst = 1'b1;
            #1;
            chk("rst_drops_spawn", 32'(spawn_o), 0);
            chk("rst_level", 32'(level_o), 0);
            en_i = 1'b0;
            model_idle();
            total = 0;
            @(posedge clk_run);
            #1;
            rst = 1'b0;
        end
        repeat (3) @(posedge clk_run);
        #1;
    endtask

    task automatic add_score(input int v, input int n);
        add_score_i = 8'(v);
        repeat (n) @(posedge clk_run);
        #1;
        add_score_i = '0;
        total += v * n;
    endtask

    task automatic bomb();
        bomb_i = 1'b1;
        @(posedge clk_run);
        #1;
        bomb_i = 1'b0;
        @(posedge clk_run);
        #1;
        if (running && !held) begin
            held      = 1;
            held_left = 90;
        end
    endtask

    initial begin
        int first1;
        int cnt;
        int x140;

        do_reset();
        chk("reset_spawn", 32'(spawn_o), 0);
        chk("reset_x", 32'(spawn_x_o), 0);
        chk("reset_level", 32'(level_o), 0);

        // First enemy1 spawn on frame 60, then reset while a spawn is live
        start();
        first1 = -1;
        for (int f = 1; f <= 119; f++) begin
            frame(-1, 0);
            if (last_sp[0] && first1 < 0) begin
                first1 = fnum;
                chk("first_x_in_range", 32'(last_x < 11'd583), 1);
            end
        end
        chk("first_spawn_frame", first1, 60);
        frame(-1, 1);

        // All three pending at frame 600, drained by priority
        do_reset();
        busy_i = 3'b011;
        start();
        for (int f = 1; f <= 599; f++) frame(-1, 0);
        busy_i = 3'b000;
        for (int f = 600; f <= 602; f++) frame(-1, 0);
        chk("prio_600", spawn_log[600], 4);
        chk("prio_601", spawn_log[601], 2);
        chk("prio_602", spawn_log[602], 1);

        // Busy class stays pending and retries
        do_reset();
        busy_i = 3'b001;
        start();
        cnt = 0;
        for (int f = 1; f <= 70; f++) begin
            frame(-1, 0);
            if (last_sp[0]) cnt++;
        end
        chk("busy_no_spawn", cnt, 0);
        busy_i = 3'b000;
        frame(-1, 0);
        chk("busy_release_spawn", 32'(last_sp), 1);

        // Level ramp shortens the enemy1 period
        do_reset();
        start();
        add_score(50, 4);
        chk("level_one", 32'(level_o), 1);
        for (int f = 1; f <= 114; f++) frame(-1, 0);
        chk("period54_a", spawn_log[60], 1);
        chk("period54_b", spawn_log[114], 1);
        add_score(100, 16);
        chk("level_sat", 32'(level_o), 7);
        chk("level_model", 32'(level_o), m_level());
        for (int f = 115; f <= 188; f++) frame(-1, 0);
        chk("period54_c", spawn_log[168], 1);
        chk("period20", spawn_log[188], 1);

        // Bomb blackout, forced x reduction, then drop en mid-hold
        do_reset();
        start();
        for (int f = 1; f <= 49; f++) frame(-1, 0);
        bomb();
        cnt = 0;
        for (int f = 50; f <= 139; f++) begin
            frame(-1, 0);
            if (last_sp != 3'b000) cnt++;
        end
        chk("bomb_quiet", cnt, 0);
        frame(1200, 0);
        x140 = int'(last_x);
        chk("bomb_release_spawn", 32'(last_sp), 1);
        chk("x_1200_mod_583", x140, 34);
        frame(-1, 0);
        bomb();
        for (int f = 142; f <= 185; f++) frame(-1, 0);
        en_i = 1'b0;
        @(posedge clk_run);
        #1;
        model_idle();
        cnt = 0;
        for (int f = 0; f < 5; f++) begin
            frame(-1, 0);
            if (last_sp != 3'b000) cnt++;
        end
        chk("idle_quiet", cnt, 0);
        start();
        frame(-1, 0);
        chk("pending_cleared", 32'(last_sp), 0);
        for (int f = 2; f <= 60; f++) frame(-1, 0);
        chk("restart_base", spawn_log[60], 1);
        chk("level_kept", 32'(level_o), m_level());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
